nco_rom_reader: RTL and testbench
=================================

// Module: nco_rom_reader
// PURPOSE
//  Phase-accumulator NCO that reads the synchronous waveform LUT: issues registered
//  address/enable to the LUT each ce_i and returns the sampled waveform value.
//  Sits between DDC control (tuning word) and the mixer; the LUT sits outside, on rom_*.
//  One sample per cycle throughput, fixed 3-cycle latency ce_i -> valid_o.
// PARAMETERS
//  PHASE_WIDTH  32  accumulator/tuning-word width; wraps modulo 2**PHASE_WIDTH
//  ADDR_WIDTH   10  LUT address width; must satisfy ADDR_WIDTH+2 <= PHASE_WIDTH
//  DATA_WIDTH    8  LUT word width; two's complement signed
// PORTS
//  clk_i        in   1            clock, all logic on rising edge
//  rst_i        in   1            reset, asynchronous, active-high
//  ce_i         in   1            produce one sample this cycle
//  inc_i        in   PHASE_WIDTH  phase increment (tuning word)
//  inc_we_i     in   1            load inc_i into increment register
//  phase_off_i  in   PHASE_WIDTH  phase offset added to accumulator for addressing only
//  phase_clr_i  in   1            synchronous accumulator clear
//  rom_en_o     out  1            LUT read enable
//  rom_addr_o   out  ADDR_WIDTH   LUT address
//  rom_data_i   in   DATA_WIDTH   LUT data, valid 1 cycle after rom_en_o/rom_addr_o
//  data_o       out  DATA_WIDTH   waveform sample
//  valid_o      out  1            data_o holds a new sample this cycle
// BEHAVIOUR
//  Reset: acc=0, inc=0, rom_en_o=0, rom_addr_o=0, data_o=0, valid_o=0, pipeline valids=0.
//  Reset mid-stream drops all in-flight samples; no valid_o until 3 cycles after next ce_i.
//  Stage0 (cycle n, ce_i=1): p = acc + phase_off_i (mod 2**PHASE_WIDTH) from pre-update acc;
//   registers rom_addr_o from p, rom_en_o<=1; acc <= acc + inc (old inc).
//  Stage1 (n+1): LUT samples address; rom_data_i valid in n+2.
//  Stage2 (n+2): data_o <= f(rom_data_i), valid_o<=1 during n+3. Else valid_o=0, data_o holds.
//  rom_en_o high exactly one cycle per accepted ce_i; rom_addr_o holds when not enabled.
//  inc_we_i: inc <= inc_i; if with ce_i same cycle, that accumulation uses old inc.
//  phase_clr_i: priority over ce_i; acc <= 0, no sample issued (rom_en_o=0 next cycle);
//   samples already in flight complete normally. First ce_i after clear addresses phase_off_i.
//  Wrap-around: acc and p wrap silently modulo 2**PHASE_WIDTH; no flag.
//  ce_i back-to-back: one valid_o per ce_i, same order, gaps preserved.
// CONFIGURATION
//  NCO_QUARTER_WAVE_EN undefined: full-wave LUT; rom_addr_o = p[PW-1 -: ADDR_WIDTH];
//   data_o = rom_data_i unmodified.
//  NCO_QUARTER_WAVE_EN defined: LUT holds first quadrant only; q = p[PW-1 -: 2],
//   idx = p[PW-3 -: ADDR_WIDTH]; rom_addr_o = q[0] ? ~idx : idx;
//   q[1] delayed 2 stages; data_o = q[1] ? -rom_data_i : rom_data_i (two's complement,
//   DATA_WIDTH wrap). Latency and handshakes unchanged.
// TESTING (PHASE_WIDTH=16, ADDR_WIDTH=8, DATA_WIDTH=8; LUT model 1-cycle registered)
//  1 full-wave, LUT data=addr, inc=0x0100, off=0, ce_i held from cycle 0 -> rom_addr_o 0,1,2..
//    from cycle 1; valid_o first high cycle 3 with data_o 0x00, then 0x01, 0x02, one/cycle.
//  2 inc=0xFF00, ce_i x3 -> addresses 0x00,0xFF,0xFE (wrap); off=0x8000 -> 0x80,0x7F,0x7E.
//  3 NCO_QUARTER_WAVE_EN, LUT data=addr&0x7F, inc=0x4000, ce_i x4 -> rom_addr_o
//    0x00,0xFF,0x00,0xFF; data_o 0x00,0x7F,0x00,0x81.
//  4 inc=0x0100 running, inc_we_i with inc_i=0x0200 and ce_i same cycle at acc=0x0300 ->
//    next addresses 0x03,0x04,0x06,0x08.
//  5 phase_clr_i with ce_i at acc=0x0500 -> rom_en_o low next cycle; next ce_i addr 0x00;
//    earlier in-flight samples still emerge on valid_o.
//  6 assert rst_i mid-stream between edges -> outputs 0 immediately; after release, no valid_o
//    until 3 cycles after the first ce_i, first address 0x00.

Source files
------------

// File: rtl/nco_rom_reader.sv
// nco_rom_reader: phase-accumulator NCO driving an external synchronous
// waveform LUT; one sample per ce_i, fixed 3-cycle latency ce_i -> valid_o.
// Ports: clk_i, rst_i (async, active-high), ce_i, inc_i/inc_we_i (tuning word),
//   phase_off_i (addressing offset), phase_clr_i (acc clear),
//   rom_en_o/rom_addr_o/rom_data_i (LUT side), data_o/valid_o (sample out).
// Build option NCO_QUARTER_WAVE_EN: LUT holds the first quadrant only;
//   address mirroring and output negation rebuild the full wave.
module nco_rom_reader #(
  parameter int PHASE_WIDTH = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   ce_i,
  input  logic [PHASE_WIDTH-1:0] inc_i,
  input  logic                   inc_we_i,
  input  logic [PHASE_WIDTH-1:0] phase_off_i,
  input  logic                   phase_clr_i,
  output logic                   rom_en_o,
  output logic [ADDR_WIDTH-1:0]  rom_addr_o,
  input  logic [DATA_WIDTH-1:0]  rom_data_i,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   valid_o
);

  localparam int PW = PHASE_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
`ifdef NCO_QUARTER_WAVE_EN
  localparam int HW = AW + 2;
`else
  localparam int HW = AW;
`endif
  localparam int LW = PW - HW;

  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] inc_q, inc_d;
  logic          rom_en_q, rom_en_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          v1_q;
  logic [DW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          issue;
  logic          cout;
  logic [HW-1:0] p_hi;
  logic [AW-1:0] addr_p;

  // Only the top HW bits of acc+offset are needed; the lower part
  // contributes just its carry.
  generate
    if (LW > 0) begin : g_lo
      logic [LW-1:0] lo_sum;
      assign lo_sum = acc_q[LW-1:0] + phase_off_i[LW-1:0];
      assign cout   = lo_sum < acc_q[LW-1:0];
    end else begin : g_nolo
      assign cout = 1'b0;
    end
  endgenerate

  assign p_hi  = acc_q[PW-1 -: HW] + phase_off_i[PW-1 -: HW] + HW'(cout);
  assign issue = ce_i && !phase_clr_i;

`ifdef NCO_QUARTER_WAVE_EN
  logic [1:0]    quad;
  logic [AW-1:0] idx;
  logic          neg0_q, neg0_d;
  logic          neg1_q;

  assign quad   = p_hi[HW-1 -: 2];
  assign idx    = p_hi[AW-1:0];
  // Odd quadrants run the quarter table backwards.
  assign addr_p = quad[0] ? ~idx : idx;
  assign neg0_d = issue ? quad[1] : neg0_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      neg0_q <= 1'b0;
      neg1_q <= 1'b0;
    end else begin
      neg0_q <= neg0_d;
      neg1_q <= neg0_q;
    end
  end
`else
  assign addr_p = p_hi;
`endif

  always_comb begin
    acc_d      = acc_q;
    inc_d      = inc_we_i ? inc_i : inc_q;
    rom_en_d   = 1'b0;
    rom_addr_d = rom_addr_q;
    if (phase_clr_i) begin
      acc_d = '0;
    end else if (ce_i) begin
      acc_d      = acc_q + inc_q;
      rom_en_d   = 1'b1;
      rom_addr_d = addr_p;
    end
    valid_d = v1_q;
    data_d  = data_q;
    if (v1_q) begin
`ifdef NCO_QUARTER_WAVE_EN
      // Lower half-wave is the negated upper half.
      data_d = neg1_q ? ({DW{1'b0}} - rom_data_i) : rom_data_i;
`else
      data_d = rom_data_i;
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q      <= '0;
      inc_q      <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      v1_q       <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      inc_q      <= inc_d;
      rom_en_q   <= rom_en_d;
      rom_addr_q <= rom_addr_d;
      v1_q       <= rom_en_q;
      data_q     <= data_d;
      valid_q    <= valid_d;
    end
  end

  assign rom_en_o   = rom_en_q;
  assign rom_addr_o = rom_addr_q;
  assign data_o     = data_q;
  assign valid_o    = valid_q;

endmodule

// File: tb/tb_nco_rom_reader.sv
// tb_nco_rom_reader: directed stimulus with a queue scoreboard; a monitor
// checks each LUT access and each output sample for value and cycle.
module tb_nco_rom_reader;

  typedef struct {
    logic [7:0] v;
    int         t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] inc = '0;
  logic [15:0] off = '0;
  logic        rom_en;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data = '0;
  logic [7:0]  data;
  logic        valid;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t aq[$];
  exp_t dq[$];
  exp_t me;

  nco_rom_reader #(
    .PHASE_WIDTH(16),
    .ADDR_WIDTH (8),
    .DATA_WIDTH (8)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .ce_i       (ce),
    .inc_i      (inc),
    .inc_we_i   (we),
    .phase_off_i(off),
    .phase_clr_i(clr),
    .rom_en_o   (rom_en),
    .rom_addr_o (rom_addr),
    .rom_data_i (rom_data),
    .data_o     (data),
    .valid_o    (valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rom_en) begin
`ifdef NCO_QUARTER_WAVE_EN
      rom_data <= rom_addr & 8'h7F;
`else
      rom_data <= rom_addr;
`endif
    end
  end

  task automatic chk(string nm, bit ok, int act, int exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rom_en) begin
        if (aq.size() == 0) begin
          chk("rom_en spurious", 1'b0, 1, 0);
        end else begin
          me = aq.pop_front();
          chk("rom_addr", rom_addr == me.v, rom_addr, me.v);
          chk("rom_en cycle", cyc == me.t, cyc, me.t);
        end
      end
      if (valid) begin
        if (dq.size() == 0) begin
          chk("valid spurious", 1'b0, 1, 0);
        end else begin
          me = dq.pop_front();
          chk("data_o", data == me.v, data, me.v);
          chk("valid cycle", cyc == me.t, cyc, me.t);
        end
      end
    end
  end

  task automatic step(bit c, bit cl, bit w, logic [15:0] iv,
                      logic [15:0] ov, logic [7:0] ea, logic [7:0] ed);
    ce  = c;
    clr = cl;
    we  = w;
    inc = iv;
    off = ov;
    if (c && !cl) begin
      aq.push_back('{ea, cyc + 1});
      dq.push_back('{ed, cyc + 3});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, 16'h0, 8'h0, 8'h0);
  endtask

  task automatic chk_zero(string nm);
    chk({nm, " rom_en"}, rom_en == 1'b0, rom_en, 0);
    chk({nm, " rom_addr"}, rom_addr == 8'h0, rom_addr, 0);
    chk({nm, " data_o"}, data == 8'h0, data, 0);
    chk({nm, " valid_o"}, valid == 1'b0, valid, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
`ifdef NCO_QUARTER_WAVE_EN
    step(0, 1, 1, 16'h4000, 16'h0, 8'h0, 8'h0);
    step(1, 0, 0, 16'h0, 16'h0, 8'h00, 8'h00);
    step(1, 0, 0, 16'h0, 16'h0, 8'hFF, 8'h7F);
    step(1, 0, 0, 16'h0, 16'h0, 8'h00, 8'h00);
    step(1, 0, 0, 16'h0, 16'h0, 8'hFF, 8'h81);
    idle(5);
`else
    // ramp: addresses 0,1,2.. data equals address
    step(0, 0, 1, 16'h0100, 16'h0, 8'h0, 8'h0);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 16'h0, 16'h0, 8'(i), 8'(i));
    // negative tuning word wrap, then with half-turn offset
    step(0, 1, 1, 16'hFF00, 16'h0, 8'h0, 8'h0);
    step(1, 0, 0, 16'h0, 16'h0, 8'h00, 8'h00);
    step(1, 0, 0, 16'h0, 16'h0, 8'hFF, 8'hFF);
    step(1, 0, 0, 16'h0, 16'h0, 8'hFE, 8'hFE);
    step(0, 1, 0, 16'h0, 16'h0, 8'h0, 8'h0);
    step(1, 0, 0, 16'h0, 16'h8000, 8'h80, 8'h80);
    step(1, 0, 0, 16'h0, 16'h8000, 8'h7F, 8'h7F);
    step(1, 0, 0, 16'h0, 16'h8000, 8'h7E, 8'h7E);
    // tuning word change together with ce_i
    step(0, 1, 1, 16'h0100, 16'h0, 8'h0, 8'h0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 16'h0, 16'h0, 8'(i), 8'(i));
    step(1, 0, 1, 16'h0200, 16'h0, 8'h03, 8'h03);
    step(1, 0, 0, 16'h0, 16'h0, 8'h04, 8'h04);
    step(1, 0, 0, 16'h0, 16'h0, 8'h06, 8'h06);
    step(1, 0, 0, 16'h0, 16'h0, 8'h08, 8'h08);
    // clear wins over ce_i; in-flight samples still complete
    step(0, 1, 1, 16'h0100, 16'h0, 8'h0, 8'h0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 16'h0, 16'h0, 8'(i), 8'(i));
    step(1, 1, 0, 16'h0, 16'h0, 8'h0, 8'h0);
    ce  = 1'b0;
    clr = 1'b0;
    @(negedge clk);
    chk("clr blocks rom_en", rom_en == 1'b0, rom_en, 0);
    @(posedge clk);
    #1;
    step(1, 0, 0, 16'h0, 16'h0, 8'h00, 8'h00);
    step(1, 0, 0, 16'h0, 16'h0, 8'h01, 8'h01);
    // asynchronous reset mid-stream
    step(1, 0, 0, 16'h0, 16'h0, 8'h02, 8'h02);
    step(1, 0, 0, 16'h0, 16'h0, 8'h03, 8'h03);
    step(1, 0, 0, 16'h0, 16'h0, 8'h04, 8'h04);
    ce = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_zero("async rst");
    aq.delete();
    dq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);
    step(1, 0, 0, 16'h0, 16'h0, 8'h00, 8'h00);
    step(0, 0, 1, 16'h0100, 16'h0, 8'h0, 8'h0);
    step(1, 0, 0, 16'h0, 16'h0, 8'h00, 8'h00);
    step(1, 0, 0, 16'h0, 16'h0, 8'h01, 8'h01);
    idle(5);
`endif
    chk("addr queue drained", aq.size() == 0, aq.size(), 0);
    chk("data queue drained", dq.size() == 0, dq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
